serial_link_port: RTL and testbench
===================================

SERIAL_LINK_PORT -- requirements
Module: serial_link_port

Interface
REQ-001 Parameter IO_BITS, default 2: serial pin width per direction; legal values 1, 2, 4, 8.
REQ-002 Parameter WORD_BITS, default 16: payload word width; SHALL be a multiple of IO_BITS.
REQ-003 Parameter MAX_PENDING, default 3: maximum outstanding fetch requests awaiting a response word, legal 1..15.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_valid  input  1  request word offered.
REQ-007 tx_ready  output  1  port accepts request this cycle.
REQ-008 tx_data  input  WORD_BITS  request payload.
REQ-009 tx_mode  input  2  bit0 = fetch (response expected), bit1 = jump.
REQ-010 rx_valid  output  1  one-cycle pulse, response word available.
REQ-011 rx_data  output  WORD_BITS  response payload, held until next rx_valid.
REQ-012 rx_err  output  1  one-cycle pulse, unsolicited response frame dropped.
REQ-013 pending  output  4  current outstanding fetch count.
REQ-014 tx_pins  output  IO_BITS  serial request data, registered.
REQ-015 tx_fetch, tx_jump  output  1 each  frame mode flags, registered.
REQ-016 rx_pins  input  IO_BITS  serial response data, asynchronous to protocol, registered once before use.

Function
REQ-017 NCYC = WORD_BITS/IO_BITS; a frame SHALL be one start cycle followed by NCYC data cycles, least-significant IO_BITS first.
REQ-018 Tx states SHALL be IDLE, START, DATA; tx_ready = (state==IDLE) and (pending < MAX_PENDING or tx_mode[0]==0).
REQ-019 Transfer occurs when tx_valid and tx_ready are both high; data and mode SHALL be captured that cycle.
REQ-020 Cycle after transfer: tx_pins = 1 (start marker), tx_fetch/tx_jump = captured mode; then NCYC cycles of data.
REQ-021 tx_fetch/tx_jump SHALL stay constant over the start and all data cycles of a frame, and be 0 in IDLE.
REQ-022 tx_pins SHALL be 0 in IDLE; after the last data cycle the tx state SHALL return to IDLE, giving a minimum request spacing of NCYC+1 cycles.
REQ-023 Rx states SHALL be IDLE, DATA; in IDLE, registered rx_pins[0]==1 SHALL start a frame, the next NCYC registered samples forming the word.
REQ-024 rx_valid SHALL pulse the cycle after the last data sample is registered if pending > 0; otherwise rx_err pulses and rx_data is unchanged.
REQ-025 No rx backpressure; a start marker seen in the cycle directly after a completed frame SHALL be accepted (back-to-back frames).
REQ-026 pending SHALL increment on transfer of a fetch request and decrement on rx_valid; both in one cycle -> unchanged; never below 0 nor above MAX_PENDING.
REQ-027 Jump-only (tx_mode=2'b10) and plain (2'b00) requests SHALL NOT affect pending and are accepted even when pending == MAX_PENDING.

Reset
REQ-028 During reset all outputs SHALL be 0 (tx_ready included), both state machines SHALL go to IDLE, pending and shift counters to 0, rx input register to 0.
REQ-029 Reset mid-frame SHALL abort the frame; tx_pins return to 0 the cycle after reset is sampled; a partly received rx word SHALL be discarded without rx_valid or rx_err.
REQ-030 tx_ready SHALL first assert the cycle after reset deasserts.

Structure
REQ-031 Shared package SHALL hold tx_mode bit positions (MODE_FETCH=0, MODE_JUMP=1), start-marker value and state encodings.
REQ-032 One sub-module, serial_shifter (parameters IO_BITS, WORD_BITS; load, shift, count-done), SHALL be instantiated for tx and for rx.
REQ-033 All pin-facing outputs SHALL come directly from flops; no combinational path from rx_pins to any output.

Verification
REQ-034 IO_BITS=2, WORD_BITS=16: send 0xA5C3 mode 2'b00 -> tx_pins 1, then 3,0,0,3,1,1,2,2 over 8 cycles, flags 0, tx_ready low 9 cycles.
REQ-035 Fetch 0x1234 then rx frame start + word 0xBEEF -> pending 1 then 0, rx_valid pulse with rx_data 0xBEEF.
REQ-036 MAX_PENDING=3: three fetches without responses -> pending 3, fourth fetch stalled (tx_ready 0), jump request still accepted with tx_jump=1.
REQ-037 Rx frame with pending 0 -> rx_err pulse, rx_valid 0, rx_data unchanged.
REQ-038 Response completing in same cycle as new fetch transfer -> pending unchanged.
REQ-039 Reset asserted at tx data cycle 4 and rx data cycle 3 -> all outputs 0 next cycle, no rx_valid/rx_err, clean frame accepted after release.

Source files
------------

// File: rtl/serial_link_port_pkg.sv
// Shared definitions for the serial link port:
// request mode bit positions, start marker and FSM encodings.
package serial_link_port_pkg;

  localparam int MODE_FETCH = 0;
  localparam int MODE_JUMP  = 1;

  localparam logic START_MARKER = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_DATA = 1'b1
  } rx_state_e;

endpackage

// File: rtl/serial_shifter.sv
// Word shift register with chunk counter, used LSB-first
// for both serialising requests and assembling responses.
module serial_shifter #(
  parameter int IO_BITS   = 2,
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] load_data,
  input  logic                 shift,
  input  logic [IO_BITS-1:0]   shift_in,
  output logic [IO_BITS-1:0]   chunk,
  output logic [WORD_BITS-1:0] word_next,
  output logic                 done
);

  localparam int NCYC = WORD_BITS / IO_BITS;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  logic [WORD_BITS-1:0] word;
  logic [CW-1:0]        count;

  if (NCYC > 1) begin : g_multi
    assign word_next = {shift_in, word[WORD_BITS-1:IO_BITS]};
  end else begin : g_single
    assign word_next = shift_in;
  end

  assign chunk = word[IO_BITS-1:0];
  // done marks the shift that moves the final chunk
  assign done  = (count == CW'(NCYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      word  <= load_data;
      count <= '0;
    end else if (shift) begin
      word  <= word_next;
      count <= done ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_link_port.sv
// Framed serial request/response port with outstanding
// fetch tracking; all pin-facing outputs are registered.
module serial_link_port
  import serial_link_port_pkg::*;
#(
  parameter int IO_BITS     = 2,
  parameter int WORD_BITS   = 16,
  parameter int MAX_PENDING = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic [1:0]           tx_mode,
  output logic                 rx_valid,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_err,
  output logic [3:0]           pending,
  output logic [IO_BITS-1:0]   tx_pins,
  output logic                 tx_fetch,
  output logic                 tx_jump,
  input  logic [IO_BITS-1:0]   rx_pins
);

  localparam logic [3:0] MAXP = 4'(MAX_PENDING);

  tx_state_e tx_state, tx_next;
  rx_state_e rx_state, rx_next;

  logic                 xfer, fetch_inc, rsp_dec;
  logic                 tx_load, tx_shift, tx_done, tx_last;
  logic [IO_BITS-1:0]   tx_chunk;
  logic [WORD_BITS-1:0] tx_word_next;
  logic [IO_BITS-1:0]   rx_q, rx_chunk;
  logic                 rx_start, rx_shift, rx_done, rx_complete;
  logic [WORD_BITS-1:0] rx_word_next;

  assign tx_ready = !reset && (tx_state == TX_IDLE) &&
                    ((pending < MAXP) || !tx_mode[MODE_FETCH]);
  assign xfer      = tx_valid && tx_ready;
  assign fetch_inc = xfer && tx_mode[MODE_FETCH];

  always_comb begin
    tx_next  = tx_state;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (xfer) begin
          tx_next = TX_START;
          tx_load = 1'b1;
        end
      end
      TX_START: begin
        tx_next  = TX_DATA;
        tx_shift = 1'b1;
      end
      TX_DATA: begin
        if (tx_last) tx_next = TX_IDLE;
        else tx_shift = 1'b1;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  serial_shifter #(.IO_BITS(IO_BITS), .WORD_BITS(WORD_BITS)) u_tx_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .load_data(tx_data),
    .shift    (tx_shift),
    .shift_in ('0),
    .chunk    (tx_chunk),
    .word_next(tx_word_next),
    .done     (tx_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_pins  <= '0;
      tx_fetch <= 1'b0;
      tx_jump  <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      // tx_last flags the cycle the final chunk is on the pins
      tx_last  <= tx_shift && tx_done;
      if (tx_load) begin
        tx_pins  <= IO_BITS'(START_MARKER);
        tx_fetch <= tx_mode[MODE_FETCH];
        tx_jump  <= tx_mode[MODE_JUMP];
      end else if (tx_shift) begin
        tx_pins <= tx_chunk;
      end else if (tx_next == TX_IDLE) begin
        tx_pins  <= '0;
        tx_fetch <= 1'b0;
        tx_jump  <= 1'b0;
      end
    end
  end

  assign rx_start    = (rx_state == RX_IDLE) && (rx_q[0] == START_MARKER);
  assign rx_shift    = (rx_state == RX_DATA);
  assign rx_complete = rx_shift && rx_done;
  assign rsp_dec     = rx_complete && (pending != 4'd0);

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE: if (rx_q[0] == START_MARKER) rx_next = RX_DATA;
      RX_DATA: if (rx_done) rx_next = RX_IDLE;
    endcase
  end

  serial_shifter #(.IO_BITS(IO_BITS), .WORD_BITS(WORD_BITS)) u_rx_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (rx_start),
    .load_data('0),
    .shift    (rx_shift),
    .shift_in (rx_q),
    .chunk    (rx_chunk),
    .word_next(rx_word_next),
    .done     (rx_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_q     <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_data  <= '0;
      pending  <= '0;
    end else begin
      rx_state <= rx_next;
      rx_q     <= rx_pins;
      rx_valid <= rsp_dec;
      rx_err   <= rx_complete && (pending == 4'd0);
      if (rsp_dec) rx_data <= rx_word_next;
      unique case ({fetch_inc, rsp_dec})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_port.sv
// Bench for serial_link_port: frame-level reference model,
// per-cycle compare, directed cases and random traffic.
module tb_serial_link_port;

  localparam int IO   = 2;
  localparam int W    = 16;
  localparam int MAXP = 3;
  localparam int NCYC = W / IO;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [W-1:0]  tx_data = '0;
  logic [1:0]    tx_mode = 2'b00;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic          rx_err;
  logic [3:0]    pending;
  logic [IO-1:0] tx_pins;
  logic          tx_fetch;
  logic          tx_jump;
  logic [IO-1:0] rx_pins = '0;

  serial_link_port #(
    .IO_BITS(IO), .WORD_BITS(W), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_mode(tx_mode),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .pending(pending),
    .tx_pins(tx_pins), .tx_fetch(tx_fetch), .tx_jump(tx_jump),
    .rx_pins(rx_pins)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: a frame is a list of per-cycle pin/flag
  // values; a response resolves a fixed time after its marker.
  typedef struct packed {
    logic [IO-1:0] pins;
    logic          f;
    logic          j;
  } txe_t;

  typedef struct packed {
    longint       due;
    logic [W-1:0] w;
  } rxe_t;

  txe_t         txq[$];
  rxe_t         rxq[$];
  txe_t         cur, ent;
  rxe_t         rsp;
  bit           busy = 0;
  bit           model_on = 0;
  bit           m_v = 0, m_e = 0, xf, dec;
  int           pend = 0;
  logic [W-1:0] m_rxdata = '0;
  longint       cyc = 0;

  always @(posedge clk) begin
    model_on = 1;
    if (reset) begin
      txq.delete();
      rxq.delete();
      cur = '0;
      busy = 0;
      pend = 0;
      m_rxdata = '0;
      m_v = 0;
      m_e = 0;
    end else begin
      xf = tx_valid && !busy && (pend < MAXP || !tx_mode[0]);
      if (xf) begin
        for (int k = 0; k <= NCYC; k++) begin
          ent.f = tx_mode[0];
          ent.j = tx_mode[1];
          if (k == 0) ent.pins = IO'(1);
          else ent.pins = tx_data[(k-1)*IO +: IO];
          txq.push_back(ent);
        end
      end
      if (txq.size() > 0) begin
        cur = txq.pop_front();
        busy = 1;
      end else begin
        cur = '0;
        busy = 0;
      end
      m_v = 0;
      m_e = 0;
      dec = 0;
      if (rxq.size() > 0 && rxq[0].due == cyc) begin
        rsp = rxq.pop_front();
        if (pend > 0) begin
          m_v = 1;
          m_rxdata = rsp.w;
          dec = 1;
        end else begin
          m_e = 1;
        end
      end
      pend = pend + int'(xf && tx_mode[0]) - int'(dec);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("tx_pins", 32'(tx_pins), 32'(cur.pins));
      chk("tx_fetch", 32'(tx_fetch), 32'(cur.f));
      chk("tx_jump", 32'(tx_jump), 32'(cur.j));
      chk("tx_ready", 32'(tx_ready),
          32'(!reset && !busy && (pend < MAXP || !tx_mode[0])));
      chk("pending", 32'(pending), 32'(pend));
      chk("rx_valid", 32'(rx_valid), 32'(m_v));
      chk("rx_err", 32'(rx_err), 32'(m_e));
      chk("rx_data", 32'(rx_data), 32'(m_rxdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [W-1:0] d, input logic [1:0] m);
    int n = 0;
    tx_valid = 1'b1;
    tx_data = d;
    tx_mode = m;
    #1;
    while (!tx_ready) begin
      step();
      n++;
      if (n == 20) tx_mode[0] = 1'b0;
      if (n > 60) begin
        checks++;
        fails++;
        $display("FAIL tx_handshake_timeout t=%0t", $time);
        break;
      end
    end
    step();
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [W-1:0] w);
    rxe_t e;
    e.due = cyc + NCYC + 1;
    e.w = w;
    rxq.push_back(e);
    rx_pins = IO'(1);
    for (int i = 0; i < NCYC; i++) begin
      step();
      rx_pins = w[i*IO +: IO];
    end
    step();
    rx_pins = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int           exp34[NCYC] = '{3, 0, 0, 3, 1, 1, 2, 2};
  logic [W-1:0] abort_word = 16'hABCD;

  initial begin
    reset = 1'b1;
    repeat (3) step();
    chk("rst_tx_pins", 32'(tx_pins), 0);
    chk("rst_flags", 32'({tx_fetch, tx_jump}), 0);
    chk("rst_ready", 32'(tx_ready), 0);
    chk("rst_rx", 32'({rx_valid, rx_err}), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_pending", 32'(pending), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(tx_ready), 1);

    send_tx(16'hA5C3, 2'b00);
    chk("t34_start", 32'(tx_pins), 1);
    chk("t34_flags", 32'({tx_fetch, tx_jump}), 0);
    chk("t34_ready_lo", 32'(tx_ready), 0);
    for (int i = 0; i < NCYC; i++) begin
      step();
      chk("t34_data", 32'(tx_pins), 32'(exp34[i]));
      chk("t34_busy", 32'(tx_ready), 0);
    end
    step();
    chk("t34_ready_back", 32'(tx_ready), 1);
    chk("t34_idle_pins", 32'(tx_pins), 0);

    send_tx(16'h1234, 2'b01);
    chk("t35_pend1", 32'(pending), 1);
    chk("t35_fetch_flag", 32'(tx_fetch), 1);
    send_rx(16'hBEEF);
    step();
    chk("t35_valid", 32'(rx_valid), 1);
    chk("t35_data", 32'(rx_data), 32'h0000BEEF);
    chk("t35_pend0", 32'(pending), 0);

    send_rx(16'h1111);
    step();
    chk("t37_err", 32'(rx_err), 1);
    chk("t37_valid", 32'(rx_valid), 0);
    chk("t37_data", 32'(rx_data), 32'h0000BEEF);

    repeat (3) send_tx(W'($urandom), 2'b01);
    chk("t36_pend3", 32'(pending), 3);
    tx_valid = 1'b1;
    tx_mode = 2'b01;
    repeat (NCYC + 3) step();
    chk("t36_stall", 32'(tx_ready), 0);
    chk("t36_pend_hold", 32'(pending), 3);
    tx_mode = 2'b10;
    #1;
    chk("t36_jump_ready", 32'(tx_ready), 1);
    step();
    tx_valid = 1'b0;
    chk("t36_jump", 32'(tx_jump), 1);
    chk("t36_nofetch", 32'(tx_fetch), 0);
    chk("t36_pend_jump", 32'(pending), 3);
    repeat (3) send_rx(W'($urandom));
    step();
    chk("t36_drain", 32'(pending), 0);

    send_tx(16'h0F0F, 2'b01);
    fork
      send_rx(16'h5555);
      begin
        repeat (NCYC + 1) step();
        send_tx(16'hF0F0, 2'b01);
      end
    join
    chk("t38_valid", 32'(rx_valid), 1);
    chk("t38_pend", 32'(pending), 1);
    send_rx(16'h7777);
    step();
    chk("t38_drain", 32'(pending), 0);

    repeat (NCYC) step();
    tx_valid = 1'b1;
    tx_data = 16'h5A5A;
    tx_mode = 2'b01;
    #1;
    chk("t39_ready", 32'(tx_ready), 1);
    step();
    tx_valid = 1'b0;
    rx_pins = IO'(1);
    for (int i = 0; i < 4; i++) begin
      step();
      rx_pins = abort_word[i*IO +: IO];
    end
    reset = 1'b1;
    step();
    rx_pins = '0;
    chk("t39_pins", 32'(tx_pins), 0);
    chk("t39_flags", 32'({tx_fetch, tx_jump}), 0);
    chk("t39_ready", 32'(tx_ready), 0);
    chk("t39_rx", 32'({rx_valid, rx_err}), 0);
    chk("t39_pend", 32'(pending), 0);
    step();
    reset = 1'b0;
    #1;
    chk("t39_ready_back", 32'(tx_ready), 1);
    repeat (NCYC + 4) step();
    send_tx(16'h2222, 2'b01);
    send_rx(16'hC0DE);
    step();
    chk("t39_clean_valid", 32'(rx_valid), 1);
    chk("t39_clean_data", 32'(rx_data), 32'h0000C0DE);

    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) step();
          send_tx(W'($urandom), 2'($urandom));
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) step();
          send_rx(W'($urandom));
        end
      end
    join
    repeat (NCYC + 4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
